// File: rtl/reg_file_32x32_pkg.sv
// Shared processor constants for the integer register file.
// Imported by reg_file_32x32 and decoder5to32.
package reg_file_32x32_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam int DATA_W_DEF = 32;

  // True when register idx accepts writes under the given ZERO_R0 setting
  function automatic logic reg_writable(input int idx, input int zero_r0);
    logic ok;
    if ((zero_r0 != 0) && (idx == 0)) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/reg_file_32x32_decoder.sv
// decoder5to32: one-hot write-enable decode of a register index, gated by en.
// Produces at most one asserted bit per cycle.
module decoder5to32
  import reg_file_32x32_pkg::*;
(
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] addr,
  output logic [REG_COUNT-1:0]  onehot
);

  // One-hot select of addr, all-zero when disabled
  always_comb begin
    onehot = {REG_COUNT{1'b0}};
    if (en) begin
      onehot[addr] = 1'b1;
    end else begin
      onehot = {REG_COUNT{1'b0}};
    end
  end

endmodule

// File: rtl/reg_file_32x32.sv
// 32-entry register file: one write port, two combinational read ports.
// Optional write-through forwarding when macro REGFILE_BYPASS_EN is defined.
module reg_file_32x32
  import reg_file_32x32_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ZERO_R0 = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0]     rd_data_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_b
);

  logic [DATA_W-1:0]     regs_r [REG_COUNT];
  logic [REG_COUNT-1:0]  we_s;
  logic [REG_ADDR_W-1:0] rd_addr_s [2];
  logic [DATA_W-1:0]     rd_data_s [2];

  decoder5to32 u_dec (
    .en     (wr_en),
    .addr   (wr_addr),
    .onehot (we_s)
  );

  // Register array: async clear, decoded single-entry write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (we_s[i] && reg_writable(i, ZERO_R0)) begin
          regs_r[i] <= wr_data;
        end
      end
    end
  end

  assign rd_addr_s[0] = rd_addr_a;
  assign rd_addr_s[1] = rd_addr_b;

  // Read muxes; reset and hard-wired r0 override both storage and forwarding
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_s[p] = {DATA_W{1'b0}};
      if (!rst_n) begin
        rd_data_s[p] = {DATA_W{1'b0}};
      end else if ((ZERO_R0 != 0) && (rd_addr_s[p] == {REG_ADDR_W{1'b0}})) begin
        rd_data_s[p] = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
      end else if (wr_en && (wr_addr == rd_addr_s[p])) begin
        rd_data_s[p] = wr_data;
`endif
      end else begin
        rd_data_s[p] = regs_r[rd_addr_s[p]];
      end
    end
  end

  assign rd_data_a = rd_data_s[0];
  assign rd_data_b = rd_data_s[1];

endmodule

// File: tb/tb_reg_file_32x32.sv
// Self-checking bench for reg_file_32x32 (ZERO_R0=1 and ZERO_R0=0 instances).
// Expected read values follow REGFILE_BYPASS_EN when that macro is defined.
module tb_reg_file_32x32;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b, rd_data_a_nz, rd_data_b_nz;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_a;
    logic [4:0]  rd_b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_nz;
  } vec_t;

  vec_t vecs[13];
  logic [31:0] model_z1 [32];
  logic [31:0] model_z0 [32];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_file_32x32 #(.DATA_W(32), .ZERO_R0(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b)
  );

  reg_file_32x32 #(.DATA_W(32), .ZERO_R0(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a_nz),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b_nz)
  );

  task automatic push_exp(input string nm, input logic [31:0] v);
    name_q.push_back(nm);
    exp_q.push_back(v);
  endtask

  task automatic pop_cmp(input logic [31:0] act);
    string       nm;
    logic [31:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %h with no expected value queued", act);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic [31:0] enz);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.rd_a = ra; v.rd_b = rb;
    v.exp_a = ea; v.exp_b = eb; v.exp_nz = enz;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] db, h99, a5;
    db  = 32'hDEADBEEF;
    h99 = 32'h00000099;
    a5  = 32'hA5A5A5A5;
    vecs[0]  = mk(1'b1, 5'd5,  db, 5'd5, 5'd5, BYP ? db : 32'd0, BYP ? db : 32'd0, BYP ? db : 32'd0);
    vecs[1]  = mk(1'b0, 5'd5,  32'd0, 5'd5, 5'd5, db, db, db);
    vecs[2]  = mk(1'b0, 5'd0,  32'd0, 5'd4, 5'd6, 32'd0, 32'd0, 32'd0);
    vecs[3]  = mk(1'b1, 5'd0,  32'h12345678, 5'd0, 5'd0, 32'd0, 32'd0, BYP ? 32'h12345678 : 32'd0);
    vecs[4]  = mk(1'b0, 5'd0,  32'd0, 5'd0, 5'd5, 32'd0, db, 32'h12345678);
    vecs[5]  = mk(1'b1, 5'd9,  h99, 5'd9, 5'd9, BYP ? h99 : 32'd0, BYP ? h99 : 32'd0, BYP ? h99 : 32'd0);
    vecs[6]  = mk(1'b0, 5'd9,  32'hFFFFFFFF, 5'd9, 5'd9, h99, h99, h99);
    vecs[7]  = mk(1'b0, 5'd9,  32'hFFFFFFFF, 5'd9, 5'd9, h99, h99, h99);
    vecs[8]  = mk(1'b0, 5'd9,  32'hFFFFFFFF, 5'd9, 5'd9, h99, h99, h99);
    vecs[9]  = mk(1'b1, 5'd12, a5, 5'd12, 5'd12, BYP ? a5 : 32'd0, BYP ? a5 : 32'd0, BYP ? a5 : 32'd0);
    vecs[10] = mk(1'b0, 5'd0,  32'd0, 5'd12, 5'd3, a5, 32'd0, a5);
    vecs[11] = mk(1'b1, 5'd0,  32'h0BAD0BAD, 5'd0, 5'd12, 32'd0, a5, BYP ? 32'h0BAD0BAD : 32'h12345678);
    vecs[12] = mk(1'b0, 5'd0,  32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h0BAD0BAD);

    // Reset active from time zero, with a write presented on a reset edge
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33333333;
    rd_addr_a = 5'd1; rd_addr_b = 5'd31;
    #1;
    push_exp("reset_rd_a_r1", 32'd0);  pop_cmp(rd_data_a);
    push_exp("reset_rd_b_r31", 32'd0); pop_cmp(rd_data_b);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; wr_en = 1'b0; rd_addr_a = 5'd3; rd_addr_b = 5'd3;
    #1;
    push_exp("write_during_reset_dropped", 32'd0); pop_cmp(rd_data_a);
    push_exp("write_during_reset_dropped_nz", 32'd0); pop_cmp(rd_data_a_nz);

    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      wr_en = vecs[k].wr_en; wr_addr = vecs[k].wr_addr; wr_data = vecs[k].wr_data;
      rd_addr_a = vecs[k].rd_a; rd_addr_b = vecs[k].rd_b;
      push_exp($sformatf("vec%0d_rd_a", k), vecs[k].exp_a);
      push_exp($sformatf("vec%0d_rd_b", k), vecs[k].exp_b);
      push_exp($sformatf("vec%0d_rd_a_nz", k), vecs[k].exp_nz);
      #1;
      pop_cmp(rd_data_a);
      pop_cmp(rd_data_b);
      pop_cmp(rd_data_a_nz);
    end

    // Sweep: r1..r31 get idx*0x01010101, then read back through both ports
    model_z1[0] = 32'd0;
    model_z0[0] = 32'h0BAD0BAD;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h01010101;
      model_z1[i] = 32'(i) * 32'h01010101;
      model_z0[i] = 32'(i) * 32'h01010101;
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
      push_exp($sformatf("sweep_a_r%0d", i), model_z1[i]);
      push_exp($sformatf("sweep_b_r%0d", 31 - i), model_z1[31 - i]);
      push_exp($sformatf("sweep_nz_a_r%0d", i), model_z0[i]);
      push_exp($sformatf("sweep_nz_b_r%0d", 31 - i), model_z0[31 - i]);
      #1;
      pop_cmp(rd_data_a);
      pop_cmp(rd_data_b);
      pop_cmp(rd_data_a_nz);
      pop_cmp(rd_data_b_nz);
    end

    // Mid-run reset: contents clear without any clock edge; forwarding suppressed
    @(negedge clk);
    #2;
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hFFFFFFFF;
    rd_addr_a = 5'd1; rd_addr_b = 5'd17;
    rst_n = 1'b0;
    #1;
    push_exp("midreset_r1", 32'd0);     pop_cmp(rd_data_a);
    push_exp("midreset_r17", 32'd0);    pop_cmp(rd_data_b);
    push_exp("midreset_nz_r1", 32'd0);  pop_cmp(rd_data_a_nz);
    rd_addr_a = 5'd31;
    #1;
    push_exp("midreset_r31", 32'd0);    pop_cmp(rd_data_a);
    push_exp("midreset_nz_r17", 32'd0); pop_cmp(rd_data_b_nz);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000077;
    rd_addr_a = 5'd1; rd_addr_b = 5'd7;
    #1;
    push_exp("post_reset_r1_cleared", 32'd0); pop_cmp(rd_data_a);
    push_exp("post_reset_r7_same_cycle", BYP ? 32'h00000077 : 32'd0); pop_cmp(rd_data_b);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    push_exp("first_write_after_reset", 32'h00000077); pop_cmp(rd_data_b);
    push_exp("first_write_after_reset_nz", 32'h00000077); pop_cmp(rd_data_b_nz);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
